// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: icache/dcache arbiter for the shared memory port with per-tag completion routing; MEM_ARB_SQUASH_EN adds icache_squash
module mem_bus_arbiter #(
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 4,
  localparam int TAG_W       = $clog2(NUM_TAGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       Icache2mem_command,
  input  logic [63:0]      Icache2mem_addr,
  input  logic [1:0]       Dcache2mem_command,
  input  logic [63:0]      Dcache2mem_addr,
  input  logic [63:0]      Dcache2mem_data,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [63:0]      mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_tag,
  output logic [1:0]       proc2mem_command,
  output logic [63:0]      proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output logic [TAG_W-1:0] Imem2proc_response,
  output logic [63:0]      Imem2proc_data,
  output logic [TAG_W-1:0] Imem2proc_tag,
  output logic [TAG_W-1:0] Dmem2proc_response,
  output logic [63:0]      Dmem2proc_data,
  output logic [TAG_W-1:0] Dmem2proc_tag,
`ifdef MEM_ARB_SQUASH_EN
  input  logic             icache_squash,
`endif
  output logic             tag_err
);
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  logic [SW-1:0]       r_starve;
  logic [NUM_TAGS-1:0] r_valid, r_owner, w_valid_nxt, w_owner_nxt;
  logic                r_tag_err;
  logic                w_i_req, w_d_req, w_grant_i, w_grant_d;
  logic                w_alloc, w_cmp, w_miss, w_realloc, w_fwd;
  logic [1:0]          w_cmd;
  assign w_i_req   = !reset && Icache2mem_command != BUS_NONE;
  assign w_d_req   = !reset && Dcache2mem_command != BUS_NONE;
  assign w_grant_i = w_i_req && (!w_d_req || r_starve == STARVE_MAX);
  assign w_grant_d = w_d_req && !w_grant_i;
  assign w_cmd     = w_grant_d ? Dcache2mem_command : w_grant_i ? Icache2mem_command : BUS_NONE;
  assign proc2mem_command   = w_cmd;
  assign proc2mem_addr      = w_grant_d ? Dcache2mem_addr : w_grant_i ? Icache2mem_addr : '0;
  assign proc2mem_data      = w_grant_d ? Dcache2mem_data : '0;
  assign Imem2proc_response = w_grant_i ? mem2proc_response : '0;
  assign Dmem2proc_response = w_grant_d ? mem2proc_response : '0;
  assign Imem2proc_data     = mem2proc_data;
  assign Dmem2proc_data     = mem2proc_data;
  assign w_alloc   = w_cmd == BUS_LOAD && mem2proc_response != '0;
  assign w_cmp     = !reset && mem2proc_tag != '0 && r_valid[mem2proc_tag];
  assign w_miss    = !reset && mem2proc_tag != '0 && !r_valid[mem2proc_tag];
  // a tag retiring in the same cycle it is reissued is a legal handoff, not a collision
  assign w_realloc = w_alloc && r_valid[mem2proc_response] && !(w_cmp && mem2proc_tag == mem2proc_response);
`ifdef MEM_ARB_SQUASH_EN
  logic [NUM_TAGS-1:0] r_squashed, w_squashed_nxt;
  assign w_fwd = w_cmp && !r_squashed[mem2proc_tag];
  always_comb begin
    w_squashed_nxt = r_squashed | ({NUM_TAGS{icache_squash}} & r_valid & ~r_owner);
    if (w_cmp) w_squashed_nxt[mem2proc_tag] = 1'b0;
    if (w_alloc) w_squashed_nxt[mem2proc_response] = 1'b0;
  end
  always_ff @(posedge clock) r_squashed <= reset ? '0 : w_squashed_nxt;
`else
  assign w_fwd = w_cmp;
`endif
  assign Imem2proc_tag = (w_fwd && !r_owner[mem2proc_tag]) ? mem2proc_tag : '0;
  assign Dmem2proc_tag = (w_fwd && r_owner[mem2proc_tag]) ? mem2proc_tag : '0;
  assign tag_err       = r_tag_err;
  always_comb begin
    w_valid_nxt = r_valid;
    w_owner_nxt = r_owner;
    if (w_cmp) w_valid_nxt[mem2proc_tag] = 1'b0;
    if (w_alloc) begin
      w_valid_nxt[mem2proc_response] = 1'b1;
      w_owner_nxt[mem2proc_response] = w_grant_d;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid   <= '0;
      r_owner   <= '0;
      r_starve  <= '0;
      r_tag_err <= 1'b0;
    end else begin
      r_valid   <= w_valid_nxt;
      r_owner   <= w_owner_nxt;
      r_starve  <= (w_i_req && !w_grant_i) ? (r_starve == STARVE_MAX ? r_starve : r_starve + 1'b1) :
                   (w_grant_i && mem2proc_response == '0) ? r_starve : '0;
      r_tag_err <= r_tag_err | w_miss | w_realloc;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table-driven directed checks of grant, routing, starvation, owner table and reset
module tb_mem_bus_arbiter;
  localparam logic [1:0] N = 2'd0, L = 2'd1, S = 2'd2;
  logic        clock = 1'b0, reset = 1'b1;
  logic [1:0]  ic_cmd, dc_cmd;
  logic [63:0] ic_addr, dc_addr, dc_data, m_data;
  logic [3:0]  m_resp, m_tag;
  logic [1:0]  p_cmd;
  logic [63:0] p_addr, p_data, i_data, d_data;
  logic [3:0]  i_resp, i_tag, d_resp, d_tag;
  logic        t_err;
`ifdef MEM_ARB_SQUASH_EN
  logic        sq = 1'b0;
`endif
  typedef struct {
    logic r; logic [1:0] ic; logic [63:0] ia; logic [1:0] dc; logic [63:0] da, dd;
    logic [3:0] rsp, tg; logic [63:0] md;
    logic [1:0] pc; logic [63:0] pa, pd; logic [3:0] ir, dr, it, dt; logic er;
  } vec_t;
  vec_t tv[23];
  int n_chk = 0, n_fail = 0, row = 0;
  always #5 clock = ~clock;
  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .Icache2mem_command(ic_cmd), .Icache2mem_addr(ic_addr),
    .Dcache2mem_command(dc_cmd), .Dcache2mem_addr(dc_addr), .Dcache2mem_data(dc_data),
    .mem2proc_response(m_resp), .mem2proc_data(m_data), .mem2proc_tag(m_tag),
    .proc2mem_command(p_cmd), .proc2mem_addr(p_addr), .proc2mem_data(p_data),
    .Imem2proc_response(i_resp), .Imem2proc_data(i_data), .Imem2proc_tag(i_tag),
    .Dmem2proc_response(d_resp), .Dmem2proc_data(d_data), .Dmem2proc_tag(d_tag),
`ifdef MEM_ARB_SQUASH_EN
    .icache_squash(sq),
`endif
    .tag_err(t_err)
  );
  function automatic vec_t v(logic r, logic [1:0] ic, logic [63:0] ia, logic [1:0] dc, logic [63:0] da,
                             logic [63:0] dd, logic [3:0] rsp, logic [3:0] tg, logic [63:0] md,
                             logic [1:0] pc, logic [63:0] pa, logic [63:0] pd, logic [3:0] ir,
                             logic [3:0] dr, logic [3:0] it, logic [3:0] dt, logic er);
    vec_t x;
    x.r = r; x.ic = ic; x.ia = ia; x.dc = dc; x.da = da; x.dd = dd; x.rsp = rsp; x.tg = tg; x.md = md;
    x.pc = pc; x.pa = pa; x.pd = pd; x.ir = ir; x.dr = dr; x.it = it; x.dt = dt; x.er = er;
    return x;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask
  task automatic run(vec_t x);
    reset = x.r; ic_cmd = x.ic; ic_addr = x.ia; dc_cmd = x.dc; dc_addr = x.da; dc_data = x.dd;
    m_resp = x.rsp; m_tag = x.tg; m_data = x.md;
    @(negedge clock);
    chk("proc2mem_command", 64'(p_cmd), 64'(x.pc));
    chk("proc2mem_addr", p_addr, x.pa);
    chk("proc2mem_data", p_data, x.pd);
    chk("Imem2proc_response", 64'(i_resp), 64'(x.ir));
    chk("Dmem2proc_response", 64'(d_resp), 64'(x.dr));
    chk("Imem2proc_tag", 64'(i_tag), 64'(x.it));
    chk("Dmem2proc_tag", 64'(d_tag), 64'(x.dt));
    chk("Imem2proc_data", i_data, x.md);
    chk("Dmem2proc_data", d_data, x.md);
    chk("tag_err", 64'(t_err), 64'(x.er));
    @(posedge clock); #1;
    row++;
  endtask
  initial begin
    //        r  ic ia      dc da      dd     rsp tg md      pc pa      pd     ir dr it dt er
    tv[0]  = v(1, L, 0,     L, 0,      0,     3,  3, 5,      N, 0,      0,     0, 0, 0, 0, 0);
    tv[1]  = v(0, L, 'h8,   N, 0,      0,     3,  0, 0,      L, 'h8,    0,     3, 0, 0, 0, 0);
    tv[2]  = v(0, N, 'h123, N, 'h456,  'h789, 0,  0, 0,      N, 0,      0,     0, 0, 0, 0, 0);
    tv[3]  = v(0, N, 0,     N, 0,      0,     0,  3, 20,     N, 0,      0,     0, 0, 3, 0, 0);
    tv[4]  = v(0, L, 'h10,  L, 'h40,   'h99,  5,  0, 0,      L, 'h40,   'h99,  0, 5, 0, 0, 0);
    tv[5]  = v(0, N, 0,     N, 0,      0,     0,  5, 'h33,   N, 0,      0,     0, 0, 0, 5, 0);
    tv[6]  = v(0, N, 0,     S, 'h80,   'hAB,  2,  0, 0,      S, 'h80,   'hAB,  0, 2, 0, 0, 0);
    tv[7]  = v(0, N, 0,     N, 0,      0,     0,  2, 'h44,   N, 0,      0,     0, 0, 0, 0, 0);
    tv[8]  = v(0, N, 0,     N, 0,      0,     0,  0, 0,      N, 0,      0,     0, 0, 0, 0, 1);
    tv[9]  = v(1, N, 0,     N, 0,      0,     0,  0, 0,      N, 0,      0,     0, 0, 0, 0, 1);
    tv[10] = v(0, N, 0,     N, 0,      0,     0,  0, 0,      N, 0,      0,     0, 0, 0, 0, 0);
    tv[11] = v(0, N, 0,     L, 'h100,  0,     7,  0, 0,      L, 'h100,  0,     0, 7, 0, 0, 0);
    tv[12] = v(0, L, 'h200, N, 0,      0,     7,  7, 'h77,   L, 'h200,  0,     7, 0, 0, 7, 0);
    tv[13] = v(0, N, 0,     N, 0,      0,     0,  7, 'h78,   N, 0,      0,     0, 0, 7, 0, 0);
    tv[14] = v(0, L, 'h300, N, 0,      0,     9,  0, 0,      L, 'h300,  0,     9, 0, 0, 0, 0);
    tv[15] = v(0, N, 0,     L, 'h400,  'h5,   9,  0, 0,      L, 'h400,  'h5,   0, 9, 0, 0, 0);
    tv[16] = v(0, N, 0,     N, 0,      0,     0,  9, 'h9,    N, 0,      0,     0, 0, 0, 9, 1);
    tv[17] = v(0, L, 'h500, N, 0,      0,     1,  0, 0,      L, 'h500,  0,     1, 0, 0, 0, 1);
    tv[18] = v(0, N, 0,     L, 'h600,  0,     2,  0, 0,      L, 'h600,  0,     0, 2, 0, 0, 1);
    tv[19] = v(0, N, 0,     L, 'h700,  0,     3,  0, 0,      L, 'h700,  0,     0, 3, 0, 0, 1);
    tv[20] = v(1, N, 0,     N, 0,      0,     0,  1, 'h11,   N, 0,      0,     0, 0, 0, 0, 1);
    tv[21] = v(0, N, 0,     N, 0,      0,     0,  1, 'h12,   N, 0,      0,     0, 0, 0, 0, 0);
    tv[22] = v(0, N, 0,     N, 0,      0,     0,  0, 0,      N, 0,      0,     0, 0, 0, 0, 1);
    ic_cmd = N; dc_cmd = N; ic_addr = 0; dc_addr = 0; dc_data = 0; m_resp = 0; m_tag = 0; m_data = 0;
    repeat (2) @(posedge clock);
    #1;
    foreach (tv[i]) run(tv[i]);
    // continuous contention: icache forced through every fifth cycle
    for (int c = 0; c < 10; c++) begin
      if (c % 5 == 4)
        run(v(0, L, 'h1000, L, 'h2000, 'hD0, 4'(c + 1), 0, 0, L, 'h1000, 0, 4'(c + 1), 0, 0, 0, 1));
      else
        run(v(0, L, 'h1000, L, 'h2000, 'hD0, 4'(c + 1), 0, 0, L, 'h2000, 'hD0, 0, 4'(c + 1), 0, 0, 1));
    end
`ifdef MEM_ARB_SQUASH_EN
    run(v(1, N, 0, N, 0, 0, 0, 0, 0, N, 0, 0, 0, 0, 0, 0, 1));
    run(v(0, L, 'h40, N, 0, 0, 4, 0, 0, L, 'h40, 0, 4, 0, 0, 0, 0));
    sq = 1'b1;
    run(v(0, L, 'h44, N, 0, 0, 6, 0, 0, L, 'h44, 0, 6, 0, 0, 0, 0));
    sq = 1'b0;
    run(v(0, N, 0, N, 0, 0, 0, 4, 'h4, N, 0, 0, 0, 0, 0, 0, 0));
    run(v(0, N, 0, N, 0, 0, 0, 6, 'h6, N, 0, 0, 0, 0, 6, 0, 0));
    run(v(0, N, 0, N, 0, 0, 0, 4, 'h4, N, 0, 0, 0, 0, 0, 0, 0));
    run(v(0, N, 0, N, 0, 0, 0, 0, 0, N, 0, 0, 0, 0, 0, 0, 1));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
